mac_array_8x8_unit: RTL and testbench
=====================================

Name:
mac_array_8x8_unit

Overview:
- Eight independent unsigned multiply-accumulate lanes sharing one clock and one reset.
- Each rising clock edge, lane i adds the product ai*bi into its own accumulator. The accumulator value is presented directly on mac_outi.
- Used as a parallel dot-product/accumulate stage; upstream logic drives operands every cycle and downstream logic samples the running sums.

Parameters:
- DATA_W, 8: operand width of each ai/bi (unsigned).
- ACC_W, 16: accumulator and output width per lane; must be >= 2*DATA_W.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- a0..a7  in  DATA_W each  lane 0..7 multiplicand, unsigned.
- b0..b7  in  DATA_W each  lane 0..7 multiplier, unsigned.
- mac_out0..mac_out7  out  ACC_W each  lane 0..7 accumulator value (registered).

Behaviour:
- Reset: rst=0 forces all eight accumulators, and therefore all mac_outi, to 0 immediately, independent of clk. Reset has priority over accumulation. While rst=0 the outputs hold 0 on every edge.
- Release: first accumulation happens at the first rising edge sampled with rst=1.
- Per lane, each rising edge with rst=1: acc_i <= acc_i + (ai * bi).
  - Product is a full 2*DATA_W-bit unsigned value, zero-extended to ACC_W.
- Accumulation is unconditional every cycle. There is no enable or clear input. Driving ai=0 or bi=0 holds the lane value.
- Latency: operands sampled at edge N are reflected on mac_outi immediately after edge N. There is 1 cycle of register latency and no combinational path from inputs to outputs.
- Overflow (default build): sum wraps modulo 2^ACC_W, with no flag.
- Lanes are fully independent: no cross-lane carry and no shared state.
- Unknown/undriven operands before first use: implementation must not propagate X into accumulators while rst=0.
- Reset mid-operation: any lane values are discarded. Accumulation restarts from 0 after release.
- Lane logic should be a generate loop over 8 identical lane instances or blocks. The discrete ports are mapped to/from internal arrays.

Optional Feature:
- Macro: MAC_ARRAY_8X8_SAT_EN.
- Defined: each lane saturates. If acc_i + product exceeds 2^ACC_W-1, the accumulator becomes all-ones (16'hFFFF at default) and stays there until reset. Zero products keep it at all-ones.
- Not defined: modulo-2^ACC_W wrap as in Behaviour. No saturation logic is synthesized.

Test Plan:
- Reset: hold rst=0 with nonzero operands for 3 edges. All mac_outi must stay 0. Asserting rst=0 between edges must clear outputs without waiting for an edge.
- Basic accumulate: release rst, then drive (a,b) = (10,3),(20,4),(30,5),(40,6),(50,7),(60,8),(70,9),(80,10).
  - After edge 1: outputs 30,80,150,240,350,480,630,800.
  - After edge 2: outputs 60,160,300,480,700,960,1260,1600.
- Hold: after the edge-2 state, drive all ai=0 with bi arbitrary for 4 edges. Outputs must remain 60..1600 unchanged.
- Overflow: lane 0 a0=255,b0=255. After edge 1 the output is 65025.
  - After edge 2, without MAC_ARRAY_8X8_SAT_EN: 64514 (130050 mod 65536).
  - After edge 2, with MAC_ARRAY_8X8_SAT_EN: 65535, which holds on later edges.
- Lane independence: drive only lane 5 nonzero (a5=3,b5=7) for 5 edges. mac_out5 must read 105 and all other lanes 0.
- Reset mid-run: after the basic-accumulate sequence, pulse rst=0 for less than one clock period, then resume the same operands. Outputs must return to 0 during the pulse, then read 30,80,...,800 after the first edge following release.

Source files
------------

// File: rtl/mac_array_8x8_unit.sv
// Eight independent unsigned MAC lanes; acc_i += a_i*b_i every cycle (MAC_ARRAY_8X8_SAT_EN: saturate, else wrap).
// Latency: 1 cycle, operands at edge N appear on mac_out after edge N; outputs are pure registers.
// Backpressure: none, every lane accumulates unconditionally each cycle.
module mac_array_8x8_unit #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] a2,
    input  logic [DATA_W-1:0] a3,
    input  logic [DATA_W-1:0] a4,
    input  logic [DATA_W-1:0] a5,
    input  logic [DATA_W-1:0] a6,
    input  logic [DATA_W-1:0] a7,
    input  logic [DATA_W-1:0] b0,
    input  logic [DATA_W-1:0] b1,
    input  logic [DATA_W-1:0] b2,
    input  logic [DATA_W-1:0] b3,
    input  logic [DATA_W-1:0] b4,
    input  logic [DATA_W-1:0] b5,
    input  logic [DATA_W-1:0] b6,
    input  logic [DATA_W-1:0] b7,
    output logic [ACC_W-1:0]  mac_out0,
    output logic [ACC_W-1:0]  mac_out1,
    output logic [ACC_W-1:0]  mac_out2,
    output logic [ACC_W-1:0]  mac_out3,
    output logic [ACC_W-1:0]  mac_out4,
    output logic [ACC_W-1:0]  mac_out5,
    output logic [ACC_W-1:0]  mac_out6,
    output logic [ACC_W-1:0]  mac_out7
);
    localparam int LANES = 8;

    logic [DATA_W-1:0] w_a   [LANES];
    logic [DATA_W-1:0] w_b   [LANES];
    logic [ACC_W-1:0]  w_acc [LANES];

    assign w_a[0] = a0;
    assign w_a[1] = a1;
    assign w_a[2] = a2;
    assign w_a[3] = a3;
    assign w_a[4] = a4;
    assign w_a[5] = a5;
    assign w_a[6] = a6;
    assign w_a[7] = a7;

    assign w_b[0] = b0;
    assign w_b[1] = b1;
    assign w_b[2] = b2;
    assign w_b[3] = b3;
    assign w_b[4] = b4;
    assign w_b[5] = b5;
    assign w_b[6] = b6;
    assign w_b[7] = b7;

    assign mac_out0 = w_acc[0];
    assign mac_out1 = w_acc[1];
    assign mac_out2 = w_acc[2];
    assign mac_out3 = w_acc[3];
    assign mac_out4 = w_acc[4];
    assign mac_out5 = w_acc[5];
    assign mac_out6 = w_acc[6];
    assign mac_out7 = w_acc[7];

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [2*DATA_W-1:0] w_prod;
        logic [ACC_W-1:0]    w_next;
        logic [ACC_W-1:0]    r_acc;

        assign w_prod = w_a[gi] * w_b[gi];

`ifdef MAC_ARRAY_8X8_SAT_EN
        // Extra carry bit detects overflow; once all-ones, a zero product keeps it there.
        logic [ACC_W:0] w_sum;
        assign w_sum  = {1'b0, r_acc} + (ACC_W+1)'(w_prod);
        assign w_next = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
`else
        assign w_next = r_acc + ACC_W'(w_prod);
`endif

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_acc <= '0;
            end else begin
                r_acc <= w_next;
            end
        end

        assign w_acc[gi] = r_acc;
    end

endmodule

// File: tb/tb_mac_array_8x8_unit.sv
// Directed self-checking bench for mac_array_8x8_unit with hand-computed lane sums.
module tb_mac_array_8x8_unit;
    logic        clk;
    logic        rst;
    logic [7:0]  a [8];
    logic [7:0]  b [8];
    logic [15:0] mo [8];

    int n_chk  = 0;
    int n_pass = 0;

    mac_array_8x8_unit #(.DATA_W(8), .ACC_W(16)) dut (
        .clk(clk), .rst(rst),
        .a0(a[0]), .a1(a[1]), .a2(a[2]), .a3(a[3]),
        .a4(a[4]), .a5(a[5]), .a6(a[6]), .a7(a[7]),
        .b0(b[0]), .b1(b[1]), .b2(b[2]), .b3(b[3]),
        .b4(b[4]), .b5(b[5]), .b6(b[6]), .b7(b[7]),
        .mac_out0(mo[0]), .mac_out1(mo[1]), .mac_out2(mo[2]), .mac_out3(mo[3]),
        .mac_out4(mo[4]), .mac_out5(mo[5]), .mac_out6(mo[6]), .mac_out7(mo[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input int exp [8]);
        for (int i = 0; i < 8; i++)
            chk($sformatf("%s_lane%0d", tag, i), mo[i], 16'(exp[i]));
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_basic();
        for (int i = 0; i < 8; i++) begin
            a[i] = 8'(10 * (i + 1));
            b[i] = 8'(i + 3);
        end
    endtask

    task automatic set_zero();
        for (int i = 0; i < 8; i++) begin
            a[i] = 8'd0;
            b[i] = 8'd0;
        end
    endtask

    // Short reset pulse placed between edges.
    task automatic pulse_rst(input string tag);
        int zeros [8];
        zeros = '{default: 0};
        rst = 1'b0;
        #2;
        chk_all(tag, zeros);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        int zeros [8];
        int e1 [8];
        int e2 [8];
        zeros = '{default: 0};
        e1 = '{30, 80, 150, 240, 350, 480, 630, 800};
        e2 = '{60, 160, 300, 480, 700, 960, 1260, 1600};

        rst = 1'b0;
        set_basic();
        #1;
        chk_all("rst_async", zeros);

        for (int k = 0; k < 3; k++) begin
            step();
            chk_all($sformatf("rst_hold%0d", k), zeros);
        end

        rst = 1'b1;
        step();
        chk_all("basic_e1", e1);
        step();
        chk_all("basic_e2", e2);

        for (int i = 0; i < 8; i++) begin
            a[i] = 8'd0;
            b[i] = 8'(255 - 17 * i);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            chk_all($sformatf("hold%0d", k), e2);
        end

        set_basic();
        pulse_rst("midrst");
        step();
        chk_all("midrst_e1", e1);

        set_zero();
        a[5] = 8'd3;
        b[5] = 8'd7;
        pulse_rst("indep_rst");
        for (int k = 0; k < 5; k++) step();
        chk_all("indep", '{0, 0, 0, 0, 0, 105, 0, 0});

        set_zero();
        a[0] = 8'd255;
        b[0] = 8'd255;
        pulse_rst("ovf_rst");
        step();
        chk("ovf_e1", mo[0], 16'd65025);
        chk("ovf_e1_lane1", mo[1], 16'd0);
        step();
`ifdef MAC_ARRAY_8X8_SAT_EN
        chk("ovf_e2_sat", mo[0], 16'd65535);
        step();
        chk("ovf_e3_sat", mo[0], 16'd65535);
        a[0] = 8'd0;
        step();
        chk("ovf_zero_sat", mo[0], 16'd65535);
`else
        chk("ovf_e2_wrap", mo[0], 16'd64514);
        step();
        chk("ovf_e3_wrap", mo[0], 16'd64003);
        a[0] = 8'd0;
        step();
        chk("ovf_zero_wrap", mo[0], 16'd64003);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
